// File: rtl/button_event_pkg.sv
// Shared types and constants for the push-button event decoder.
package button_event_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  localparam int unsigned TCNT_W = 8;
  localparam logic [TCNT_W-1:0] TCNT_MAX = '1;

endpackage

// File: rtl/button_event_if.sv
// Button level in, decoded event pulses out; master drives the level, slave decodes.
interface button_event_if;
  logic button_db;
  logic held;
  logic press_p;
  logic release_p;
  logic click_p;
  logic dbl_p;
  logic long_p;

  modport master (
    output button_db,
    input  held, press_p, release_p, click_p, dbl_p, long_p
  );

  modport slave (
    input  button_db,
    output held, press_p, release_p, click_p, dbl_p, long_p
  );
endinterface

// File: rtl/button_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks, never restarted by activity.
module button_tick_gen #(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/button_event.sv
// Decodes a debounced button level into press/release/click/double-click/long-press pulses.
module button_event
  import button_event_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 500000,
  parameter int unsigned LONG_TICKS = 100,
  parameter int unsigned DBL_TICKS  = 30
) (
  input  logic          clk,
  input  logic          rst_n,
  button_event_if.slave bus
);

  if (TICK_DIV < 2 || LONG_TICKS < 1 || LONG_TICKS > 255 ||
      DBL_TICKS < 1 || DBL_TICKS > 255) begin : g_param_check
    $error("button_event: illegal TICK_DIV/LONG_TICKS/DBL_TICKS");
  end

  localparam logic [TCNT_W-1:0] LONG_LAST = TCNT_W'(LONG_TICKS - 1);
  localparam logic [TCNT_W-1:0] DBL_LAST  = TCNT_W'(DBL_TICKS - 1);

  logic              btn_q;
  logic              btn_q2;
  logic              rise;
  logic              fall;
  logic              tick;
  state_t            state;
  state_t            state_n;
  logic [TCNT_W-1:0] tcnt;
  logic              long_n;
  logic              click_n;
  logic              dbl_n;

  button_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q  <= 1'b0;
      btn_q2 <= 1'b0;
    end else begin
      btn_q  <= bus.button_db;
      btn_q2 <= btn_q;
    end
  end

  assign rise     = btn_q & ~btn_q2;
  assign fall     = ~btn_q & btn_q2;
  assign bus.held = btn_q2;

  // Edges are tested before threshold ticks so a coincident edge always wins.
  always_comb begin
    state_n = state;
    long_n  = 1'b0;
    click_n = 1'b0;
    dbl_n   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_n = PRESS1;
      end
      PRESS1: begin
        if (fall) begin
          state_n = GAP;
        end else if (tick && tcnt == LONG_LAST) begin
          state_n = LONG;
          long_n  = 1'b1;
        end
      end
      GAP: begin
        if (rise) begin
          state_n = PRESS2;
        end else if (tick && tcnt == DBL_LAST) begin
          state_n = IDLE;
          click_n = 1'b1;
        end
      end
      PRESS2: begin
        if (fall) begin
          state_n = IDLE;
          dbl_n   = 1'b1;
        end else if (tick && tcnt == LONG_LAST) begin
          state_n = LONG;
          long_n  = 1'b1;
        end
      end
      LONG: begin
        if (fall) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tcnt          <= '0;
      bus.press_p   <= 1'b0;
      bus.release_p <= 1'b0;
      bus.click_p   <= 1'b0;
      bus.dbl_p     <= 1'b0;
      bus.long_p    <= 1'b0;
    end else begin
      state         <= state_n;
      bus.press_p   <= rise;
      bus.release_p <= fall;
      bus.click_p   <= click_n;
      bus.dbl_p     <= dbl_n;
      bus.long_p    <= long_n;
      if (state_n != state) begin
        tcnt <= '0;
      end else if (tick && tcnt != TCNT_MAX) begin
        tcnt <= tcnt + TCNT_W'(1);
      end
    end
  end

endmodule

// File: doc/button_event.md
# button_event

Decodes the debounced push-button level into single-cycle user events: press, release, click, double-click and long-press. It sits directly downstream of the debouncer, in the same clock domain. It feeds the control/menu logic that selects VGA test patterns and DDR2 test modes. All timing is measured in prescaled ticks, so the thresholds are in human-scale milliseconds.

## Interface
- TICK_DIV, 500000, clk cycles per tick (10 ms at 50 MHz); must be ≥ 2
- LONG_TICKS, 100, hold duration in ticks that qualifies a long press; legal range 1..255
- DBL_TICKS, 30, maximum gap in ticks between release and second press for a double-click; legal range 1..255
- clk  in  1  system clock; the only clock
- rst_n  in  1  reset, asynchronous assert, active-low
- button_db  in  1  debounced button level, 1 = pressed, synchronous to clk
- held  out  1  registered copy of the button level (btn_q2)
- press_p  out  1  one-cycle pulse on each rising edge of the button
- release_p  out  1  one-cycle pulse on each falling edge of the button
- click_p  out  1  single short press, confirmed after the double-click window expires
- dbl_p  out  1  double-click, pulsed on the second release
- long_p  out  1  long press, pulsed once when the hold threshold is reached

## Operation
- Input pipeline: btn_q <= button_db; btn_q2 <= btn_q.
  - rise = btn_q & ~btn_q2
  - fall = ~btn_q & btn_q2
- Tick generator: a free-running counter counts 0..TICK_DIV-1 and wraps. tick = 1 for one cycle when the count equals TICK_DIV-1. It is not restarted by button activity.
- tcnt: an 8-bit tick counter. It clears on every FSM state change and increments on tick, saturating at 255.
- FSM states are IDLE, PRESS1, GAP, PRESS2, LONG. Transitions:
  - IDLE: rise -> PRESS1.
  - PRESS1:
    - fall -> GAP.
    - tick with tcnt == LONG_TICKS-1 -> LONG and pulse long_p.
  - GAP:
    - rise -> PRESS2.
    - tick with tcnt == DBL_TICKS-1 -> IDLE and pulse click_p.
  - PRESS2:
    - fall -> IDLE and pulse dbl_p.
    - tick with tcnt == LONG_TICKS-1 -> LONG and pulse long_p; no dbl_p is ever issued for this sequence.
  - LONG: fall -> IDLE. No click_p or dbl_p.
- press_p and release_p follow rise and fall in every state, independent of the FSM.
- Simultaneous events: a button edge always wins over a threshold expiry in the same cycle.
  - PRESS1 fall + long tick -> GAP, no long_p.
  - GAP rise + window tick -> PRESS2, no click_p.
- Reset (async, any time) clears:
  - the state machine, to IDLE;
  - the counters (prescaler and tcnt);
  - btn_q and btn_q2;
  - all outputs, to 0.
  A pending click is discarded. A button held through reset release produces press_p two edges later and starts a fresh PRESS1.

## Timing
- All outputs are registered, and every pulse is exactly one clk cycle wide.
- press_p/release_p latency: button_db changes before edge E. btn_q captures it at E, and the pulse is high after edge E+1. The FSM state changes at the same edge E+1. held follows button_db with the same two-edge latency.
- long_p fires at the edge where tcnt reaches LONG_TICKS, counted from entry to PRESS1. The elapsed time since press_p is between (LONG_TICKS-1)·TICK_DIV+1 and LONG_TICKS·TICK_DIV cycles; the jitter comes from the free-running prescaler.
- click_p fires DBL_TICKS ticks after entry to GAP, with the same jitter rule.
- dbl_p is asserted in the same cycle as the corresponding release_p.
- No event pulse coincides with another FSM pulse. press_p may coincide with nothing but held rising.

## Structure
- Shared package button_event_pkg holds:
  - the state enum (IDLE, PRESS1, GAP, PRESS2, LONG; 3-bit encoding);
  - TCNT_W = 8;
  - the TCNT_MAX constant.
- Sub-module button_tick_gen (parameter TICK_DIV; ports clk, rst_n, tick) contains the prescaler. The counter width is $clog2(TICK_DIV).
- Parameter legality is checked at elaboration with a static assertion.

## Test plan
All scenarios use TICK_DIV=4, LONG_TICKS=5, DBL_TICKS=3.
1. Press for 6 clk, then release and idle 40 clk -> press_p, release_p, then exactly one click_p, which arrives 9–12 clk after release_p. No dbl_p or long_p.
2. Press 6 clk, release 4 clk, press 6 clk, release -> two press_p, two release_p, one dbl_p coincident with the second release_p. No click_p.
3. Hold for 30 clk -> long_p 17–20 clk after press_p. Release gives release_p only. No click_p or dbl_p.
4. Force a fall in the same cycle as the 5th tick in PRESS1 -> no long_p. FSM enters GAP and click_p follows. Force a rise coincident with the GAP expiry tick -> no click_p, and dbl_p occurs on the next release.
5. Assert rst_n=0 while in GAP, with the button held low and then high across reset release -> all outputs 0 during reset, no stale click_p, press_p exactly 2 edges after rst_n rises.
6. Set DBL_TICKS=1 and LONG_TICKS=255 (saturation boundary); hold 1100 clk -> single long_p, tcnt never wraps, no second long_p.
